vid_fbmem_tgt: RTL and testbench
================================

# vid_fbmem_tgt

Frame-buffer memory target for the video bus: the responder end of the burst-read and register/memory-write transactions that the video controller initiates. It accepts a read request (address plus burst length), bids for the bus, and returns the burst as data-phase beats. It also accepts write bursts and answers each completed burst with a write response. It sits between the bus arbiter and a synchronous word-addressed RAM that holds pixel data fetched from `base_address`.

## Interface
- `DEPTH`, 4096: RAM size in 32-bit words; must be a power of 2.
- `REPLY_TAR`, 4'd0: target ID driven on `reqtar` when bidding; this is the video controller's ID.
- `clk` in 1: sole clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low; asserting it forces every register and output to its reset value.
- `selin` in 1: this target is selected; `cmdin` is ignored when `selin`=0.
- `cmdin` in 3: 000 idle, 010 read request, 100 write request, 011 write data.
- `lenin` in 2: burst length code; 00→1, 01→2, 10→4, 11→8 beats.
- `addrdatain` in 32: byte address on request cycles, data on write-data cycles.
- `ackin` in 1: arbiter grant for this target's bid.
- `reqout` out 2: bus bid; 2'b11 while bidding, otherwise 0.
- `reqtar` out 4: `REPLY_TAR` while bidding, otherwise 0.
- `cmdout` out 3: 001 read data, 101 write response, otherwise 000.
- `lenout` out 2: echo of the latched `lenin` during a response, otherwise 0.
- `addrdataout` out 32: read data, or the write start address during a write response, otherwise 0.

## Operation
- States: IDLE, WR_DATA, BID, RD_DATA, WR_RESP. A 1-bit `is_rd` flag selects the path taken after BID.
- IDLE:
  - `selin && cmdin==010`: latch the address and length, set `is_rd`=1, go to BID.
  - `selin && cmdin==100`: latch the address and length, set `is_rd`=0, go to WR_DATA.
  - Any other cmd: stay in IDLE.
- WR_DATA:
  - Each cycle with `selin && cmdin==011` writes `addrdatain` to RAM at the current word and increments the beat counter.
  - Other cycles stall with no write.
  - After the last beat, go to BID.
- BID: drive `reqout`=11 and `reqtar`=REPLY_TAR until `ackin` is sampled 1. Then go to RD_DATA or WR_RESP according to `is_rd`; the bid drops on that same edge.
- RD_DATA:
  - Drives one beat per cycle with no stalls: `cmdout`=001, `lenout`=latched length, `addrdataout`=mem[word].
  - The word index increments by 1 per beat.
  - After the last beat, go to IDLE.
- WR_RESP: drives one cycle of `cmdout`=101, `lenout`=latched length, `addrdataout`=latched start address, then goes to IDLE.
- Addressing:
  - RAM word index = `addr[$clog2(DEPTH)+1:2]`; `addr[1:0]` is ignored.
  - Burst increments wrap modulo `DEPTH`. Upper address bits are not decoded, so aliasing is accepted.
- Requests arriving in any state other than IDLE are dropped silently. Only one transaction is outstanding at a time.

## Timing
- All outputs are registered. Reset value of every output is 0. State resets to IDLE and the counters reset to 0. RAM contents are not reset.
- Read latency:
  - Request sampled at edge N → `reqout` high from cycle N+1.
  - `ackin` sampled at edge M (M ≥ N+1) → first data beat in cycle M+1.
  - Beats are contiguous; the last beat is in cycle M+beats.
- RAM reads are synchronous (1 cycle). The read of word k+1 is issued during beat k, so no bubbles occur.
- A write-data beat is written on the edge where it is sampled. A read request accepted the cycle after a write response returns the new data.
- `ackin` while not in BID is ignored.
- `reset` asserted mid-burst: outputs go to 0 immediately (asynchronously). Any partially written burst keeps the beats already written.

## Structure
- `vid_bus_pkg` holds:
  - the cmd localparams CMD_IDLE/RDREQ/RDDATA/WRREQ/WRDATA/WRRESP;
  - a function `len2beats(logic [1:0]) → logic [3:0]`;
  - the state enum.
- One sub-module, `fb_mem_array`: single-port synchronous RAM, `DEPTH`×32, one write port, registered read data, no reset.

## Test plan
- Write burst: cmd 100 @0x100 with len 10, then four 011 beats 0xA0..0xA3 → one cycle of cmd 101, `lenout`=10, `addrdataout`=0x100, produced after the grant.
- Read back: cmd 010 @0x100 with len 10, `ackin` held low for 3 cycles after the bid starts, then pulsed → 4 contiguous beats 0xA0..0xA3 starting the cycle after `ackin`, `reqout`=0 during the beats.
- Wrap: with DEPTH=16, write 8 beats starting at 0x38 (word 14), then read 8 beats from 0x38 → data written to words 14,15,0..5 reads back in that order.
- Stalled write plus ignored request: gaps in `cmdin`=011 and a `selin`=0 beat cause no write; a cmd 010 arriving during WR_DATA is dropped (no extra response).
- `reset` pulled low during beat 2 of an 8-beat read → all outputs 0 in the same cycle, state IDLE; a fresh read after release returns correct data.

Source files
------------

// File: rtl/vid_bus_pkg.sv
// Shared video-bus definitions: command codes, burst-length decode, target FSM states
// and the registered bus-output bundle.
package vid_bus_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAR_W  = 4;
  localparam int unsigned REQ_W  = 2;
  localparam int unsigned BEAT_W = 4;

  localparam logic [CMD_W-1:0] CMD_IDLE   = 3'b000;
  localparam logic [CMD_W-1:0] CMD_RDREQ  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_RDDATA = 3'b001;
  localparam logic [CMD_W-1:0] CMD_WRREQ  = 3'b100;
  localparam logic [CMD_W-1:0] CMD_WRDATA = 3'b011;
  localparam logic [CMD_W-1:0] CMD_WRRESP = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_BID,
    ST_RD_DATA,
    ST_WR_RESP
  } state_e;

  typedef struct packed {
    logic [REQ_W-1:0]  req;
    logic [TAR_W-1:0]  tar;
    logic [CMD_W-1:0]  cmd;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] addrdata;
  } bus_out_t;

  // Burst length code to beat count: 1, 2, 4 or 8.
  function automatic logic [BEAT_W-1:0] len2beats(input logic [LEN_W-1:0] len);
    case (len)
      2'b00:   len2beats = 4'd1;
      2'b01:   len2beats = 4'd2;
      2'b10:   len2beats = 4'd4;
      default: len2beats = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/fb_mem_array.sv
// Single-port synchronous frame-buffer RAM, DEPTH x 32, registered read data.
module fb_mem_array #(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vid_fbmem_tgt.sv
// Video-bus frame-buffer target: accepts read/write bursts, bids for the bus and
// returns read beats or a write response from a word-addressed synchronous RAM.
module vid_fbmem_tgt
  import vid_bus_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [3:0]  REPLY_TAR = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic                is_rd_q, is_rd_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [AW-1:0]       word_q, word_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic                last_beat_c;
  logic                we_c;
  logic [AW-1:0]       mem_addr_c;
  logic [DATA_W-1:0]   rd_data;
  bus_out_t            bus_d, bus_q;

  assign last_beat_c = (cnt_q == len2beats(len_q) - 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    len_d   = len_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    we_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (selin && (cmdin == CMD_RDREQ || cmdin == CMD_WRREQ)) begin
          is_rd_d = (cmdin == CMD_RDREQ);
          len_d   = lenin;
          addr_d  = addrdatain;
          word_d  = addrdatain[AW+1:2];
          cnt_d   = '0;
          state_d = (cmdin == CMD_RDREQ) ? ST_BID : ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (selin && cmdin == CMD_WRDATA) begin
          we_c   = 1'b1;
          word_d = word_q + AW'(1);
          if (last_beat_c) begin
            cnt_d   = '0;
            state_d = ST_BID;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_BID: begin
        if (ackin) begin
          state_d = is_rd_q ? ST_RD_DATA : ST_WR_RESP;
          if (is_rd_q) begin
            word_d = word_q + AW'(1);
          end
        end
      end
      ST_RD_DATA: begin
        word_d = word_q + AW'(1);
        if (last_beat_c) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WR_RESP: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_d = '0;
    case (state_d)
      ST_BID: begin
        bus_d.req = 2'b11;
        bus_d.tar = REPLY_TAR;
      end
      ST_RD_DATA: begin
        bus_d.cmd      = CMD_RDDATA;
        bus_d.len      = len_q;
        bus_d.addrdata = rd_data;
      end
      ST_WR_RESP: begin
        bus_d.cmd      = CMD_WRRESP;
        bus_d.len      = len_q;
        bus_d.addrdata = addr_q;
      end
      default: bus_d = '0;
    endcase
  end

  // RAM address runs one word ahead of the beat being presented so reads stay bubble-free.
  always_comb begin
    case (state_q)
      ST_IDLE:    mem_addr_c = addrdatain[AW+1:2];
      ST_BID:     mem_addr_c = ackin ? word_q + AW'(1) : word_q;
      ST_RD_DATA: mem_addr_c = word_q + AW'(1);
      default:    mem_addr_c = word_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_rd_q <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
    end else begin
      is_rd_q <= is_rd_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
    end
  end

  fb_mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we_c),
    .addr  (mem_addr_c),
    .wdata (addrdatain),
    .rdata (rd_data)
  );

  assign reqout      = bus_q.req;
  assign reqtar      = bus_q.tar;
  assign cmdout      = bus_q.cmd;
  assign lenout      = bus_q.len;
  assign addrdataout = bus_q.addrdata;

endmodule

// File: tb/tb_vid_fbmem_tgt.sv
// Bench for vid_fbmem_tgt: directed and randomized bursts checked against a
// transaction-level memory model.
module tb_vid_fbmem_tgt;
  import vid_bus_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam logic [3:0]  TAR   = 4'hA;

  logic        clk = 1'b0;
  logic        reset;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] wd [8];
  logic [31:0] ra;
  logic [1:0]  rl;

  vid_fbmem_tgt #(
    .DEPTH     (DEPTH),
    .REPLY_TAR (TAR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .selin       (selin),
    .cmdin       (cmdin),
    .lenin       (lenin),
    .addrdatain  (addrdatain),
    .ackin       (ackin),
    .reqout      (reqout),
    .reqtar      (reqtar),
    .cmdout      (cmdout),
    .lenout      (lenout),
    .addrdataout (addrdataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] req, input logic [3:0] tar,
                         input logic [2:0] cmd, input logic [1:0] len, input logic [31:0] d);
    chk({tag, ".reqout"}, 32'(reqout), 32'(req));
    chk({tag, ".reqtar"}, 32'(reqtar), 32'(tar));
    chk({tag, ".cmdout"}, 32'(cmdout), 32'(cmd));
    chk({tag, ".lenout"}, 32'(lenout), 32'(len));
    chk({tag, ".addrdataout"}, addrdataout, d);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [2:0] cmd, input logic [1:0] len,
                       input logic [31:0] ad, input logic ack);
    selin      = sel;
    cmdin      = cmd;
    lenin      = len;
    addrdatain = ad;
    ackin      = ack;
  endtask

  // Random traffic that a busy target must ignore (never asserts ackin).
  task automatic drive_junk();
    logic [2:0] c;
    case ($urandom_range(3))
      0:       c = CMD_IDLE;
      1:       c = CMD_RDREQ;
      2:       c = CMD_WRREQ;
      default: c = CMD_WRDATA;
    endcase
    drive(1'($urandom_range(1)), c, 2'($urandom_range(3)), $urandom, 1'b0);
  endtask

  function automatic int word_of(input logic [31:0] addr, input int b);
    return int'(((addr >> 2) + 32'(b)) % DEPTH);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] d [8], input int stall_pct, input int ack_dly);
    int beats;
    beats = 1 << len;
    drive(1'b1, CMD_WRREQ, len, addr, 1'b0);
    cyc();
    for (int b = 0; b < beats; b++) begin
      for (int s = 0; s < 3 && int'($urandom_range(99)) < stall_pct; s++) begin
        case ($urandom_range(2))
          0:       drive(1'b1, CMD_IDLE, 2'd0, $urandom, 1'b0);
          1:       drive(1'b0, CMD_WRDATA, 2'd0, $urandom, 1'b0);
          default: drive(1'b1, CMD_RDREQ, 2'($urandom_range(3)), $urandom, 1'b0);
        endcase
        cyc();
        chk_bus("wr_stall", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
      end
      drive(1'b1, CMD_WRDATA, 2'd0, d[b], 1'b0);
      cyc();
      mem_m[word_of(addr, b)] = d[b];
      if (b < beats - 1) chk_bus("wr_beat", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
    end
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b0);
    for (int i = 0; i < ack_dly; i++) begin
      chk_bus("wr_bid", 2'b11, TAR, CMD_IDLE, 2'd0, 32'd0);
      drive_junk();
      cyc();
    end
    chk_bus("wr_bid", 2'b11, TAR, CMD_IDLE, 2'd0, 32'd0);
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b1);
    cyc();
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b0);
    chk_bus("wr_resp", 2'd0, 4'd0, CMD_WRRESP, len, addr);
    cyc();
    chk_bus("wr_done", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input int ack_dly);
    int beats;
    beats = 1 << len;
    drive(1'b1, CMD_RDREQ, len, addr, 1'b0);
    cyc();
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b0);
    for (int i = 0; i < ack_dly; i++) begin
      chk_bus("rd_bid", 2'b11, TAR, CMD_IDLE, 2'd0, 32'd0);
      drive_junk();
      cyc();
    end
    chk_bus("rd_bid", 2'b11, TAR, CMD_IDLE, 2'd0, 32'd0);
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b1);
    cyc();
    for (int b = 0; b < beats; b++) begin
      chk_bus("rd_beat", 2'd0, 4'd0, CMD_RDDATA, len, mem_m[word_of(addr, b)]);
      drive_junk();
      cyc();
    end
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b0);
    chk_bus("rd_done", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b0);
    repeat (3) cyc();
    chk_bus("reset", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
    reset = 1'b1;
    cyc();
    chk_bus("post_reset", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);

    // Fill the whole RAM so every later read has known contents.
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 8; i++) wd[i] = $urandom;
      do_write(32'(h * 32), 2'd3, wd, 0, 0);
    end

    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    do_write(32'h100, 2'd2, wd, 60, 1);
    do_read(32'h100, 2'd2, 3);

    for (int i = 0; i < 8; i++) wd[i] = $urandom;
    do_write(32'h38, 2'd3, wd, 30, 2);
    do_read(32'h38, 2'd3, 0);

    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b1);
    cyc();
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b0);
    chk_bus("idle_ack", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);

    for (int it = 0; it < 30; it++) begin
      ra = $urandom;
      rl = 2'($urandom_range(3));
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        do_write(ra, rl, wd, int'($urandom_range(50)), int'($urandom_range(3)));
      end else begin
        do_read(ra, rl, int'($urandom_range(3)));
      end
    end

    // Reset in the middle of beat 2 of an 8-beat read.
    ra = 32'hFFFF_FF24;
    drive(1'b1, CMD_RDREQ, 2'd3, ra, 1'b0);
    cyc();
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b1);
    cyc();
    drive(1'b0, CMD_IDLE, 2'd0, 32'd0, 1'b0);
    cyc();
    cyc();
    chk_bus("pre_rst_beat2", 2'd0, 4'd0, CMD_RDDATA, 2'd3, mem_m[word_of(ra, 2)]);
    #2 reset = 1'b0;
    #1 chk_bus("mid_rst", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    cyc();
    chk_bus("rst_release", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
    cyc();
    chk_bus("rst_idle", 2'd0, 4'd0, CMD_IDLE, 2'd0, 32'd0);
    do_read(ra, 2'd3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
